// File: rtl/xpb_accum_pkg.sv
// Shared defaults, FSM state encoding and datapath typedefs for the xpb accumulator sequencer.
package xpb_accum_pkg;

  localparam int DEF_WIDTH    = 1024;
  localparam int DEF_SEG_BITS = 5;
  localparam int DEF_NUM_SEG  = 14;
  localparam int DEF_GUARD    = 4;
  localparam int DEF_IDX_W    = (DEF_NUM_SEG > 1) ? $clog2(DEF_NUM_SEG) : 1;

  typedef logic [DEF_IDX_W-1:0]           idx_t;
  typedef logic [DEF_WIDTH+DEF_GUARD-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/xpb_seg_sel.sv
// Priority finder: lowest set bit of a pending-segment mask, plus a flag when nothing is pending.
module xpb_seg_sel
  import xpb_accum_pkg::*;
#(
  parameter int N  = DEF_NUM_SEG,
  parameter int IW = DEF_IDX_W
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          none_o
);

  // NOTE: outputs get defaults before the loop so every path assigns them and no latch is inferred.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_i[k]) begin
        idx_o  = IW'(k);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xpb_accum_seq.sv
// Issues overflow segments to the xpb LUT bank and sums the returned constants onto the lower part.
// Optional XPB_ACCUM_SKIP_ZERO_EN: issue only nonzero segments (default: issue all NUM_SEG in order).
module xpb_accum_seq
  import xpb_accum_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int SEG_BITS = DEF_SEG_BITS,
  parameter  int NUM_SEG  = DEF_NUM_SEG,
  parameter  int GUARD    = DEF_GUARD,
  localparam int IDX_W    = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  localparam int UP_W     = NUM_SEG * SEG_BITS,
  localparam int ACC_W    = WIDTH + GUARD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_lower,
  input  logic [UP_W-1:0]     in_upper,
  output logic                lut_req,
  output logic [IDX_W-1:0]    lut_idx,
  output logic [SEG_BITS-1:0] lut_sel,
  input  logic [WIDTH-1:0]    lut_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data
);

  if ((2 ** GUARD) < (NUM_SEG + 1)) begin : g_guard_chk
    $error("GUARD too small to absorb NUM_SEG LUT additions");
  end

  state_e              state_q;
  logic                in_ready_q, lut_req_q, out_valid_q, flag_q;
  logic [IDX_W-1:0]    lut_idx_q;
  logic [SEG_BITS-1:0] lut_sel_q;
  logic [UP_W-1:0]     upper_q;
  logic [ACC_W-1:0]    acc_q;

  logic                accept, issue_slot, nxt_any;
  logic [IDX_W-1:0]    nxt_idx;
  logic [SEG_BITS-1:0] nxt_sel;
  logic [UP_W-1:0]     src_upper;

  assign accept     = (state_q == IDLE) && in_ready_q && in_valid;
  assign issue_slot = accept || (state_q == ISSUE);
  // On the accept edge the shadow register is not loaded yet, so select from the live input.
  assign src_upper  = (state_q == IDLE) ? in_upper : upper_q;
  assign nxt_sel    = src_upper[nxt_idx*SEG_BITS +: SEG_BITS];

`ifdef XPB_ACCUM_SKIP_ZERO_EN
  logic [NUM_SEG-1:0] nz_mask, mask_src, pend_nxt, pend_q;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_none;

  always_comb begin
    nz_mask = '0;
    for (int k = 0; k < NUM_SEG; k++) nz_mask[k] = |in_upper[k*SEG_BITS +: SEG_BITS];
  end

  assign mask_src = (state_q == IDLE) ? nz_mask : pend_q;

  xpb_seg_sel #(
    .N  (NUM_SEG),
    .IW (IDX_W)
  ) u_seg_sel (
    .mask_i (mask_src),
    .idx_o  (sel_idx),
    .none_o (sel_none)
  );

  assign nxt_any  = ~sel_none;
  assign nxt_idx  = sel_idx;
  assign pend_nxt = mask_src & ~(NUM_SEG'(1) << sel_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pend_q <= '0;
    else if (issue_slot) pend_q <= pend_nxt;
  end
`else
  assign nxt_any = (state_q == IDLE) || (lut_idx_q != IDX_W'(NUM_SEG - 1));
  assign nxt_idx = (state_q == IDLE) ? '0 : lut_idx_q + 1'b1;
`endif

  // NOTE: every register here uses nonblocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      lut_req_q   <= 1'b0;
      lut_idx_q   <= '0;
      lut_sel_q   <= '0;
      out_valid_q <= 1'b0;
      upper_q     <= '0;
    end else begin
      if (issue_slot) begin
        lut_req_q <= nxt_any;
        if (nxt_any) begin
          lut_idx_q <= nxt_idx;
          lut_sel_q <= nxt_sel;
        end
      end
      case (state_q)
        IDLE: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (in_valid) begin
            in_ready_q <= 1'b0;
            upper_q    <= in_upper;
            state_q    <= ISSUE;
          end
        end
        ISSUE: if (!nxt_any) state_q <= DRAIN;
        DRAIN: begin
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The flag marks the cycle lut_data belongs to the previous request; reset drops stale returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      flag_q <= lut_req_q;
      if (accept)      acc_q <= {{GUARD{1'b0}}, in_lower};
      else if (flag_q) acc_q <= acc_q + {{GUARD{1'b0}}, lut_data};
    end
  end

  assign in_ready  = in_ready_q;
  assign lut_req   = lut_req_q;
  assign lut_idx   = lut_idx_q;
  assign lut_sel   = lut_sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_xpb_accum_seq.sv
// Self-checking bench for xpb_accum_seq: registered LUT bank, transaction-level model, directed and random traffic.
module tb_xpb_accum_seq;
  import xpb_accum_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int SB = DEF_SEG_BITS;
  localparam int NS = DEF_NUM_SEG;
  localparam int G  = DEF_GUARD;
  localparam int IW = DEF_IDX_W;
  localparam int UW = NS * SB;
  localparam int AW = W + G;
`ifdef XPB_ACCUM_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, lut_req, out_valid;
  logic [W-1:0]  in_lower = '0, lut_data = '0;
  logic [UW-1:0] in_upper = '0;
  logic [IW-1:0] lut_idx;
  logic [SB-1:0] lut_sel;
  logic [AW-1:0] out_data;

  always #5 clk = ~clk;

  xpb_accum_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lower  (in_lower),
    .in_upper  (in_upper),
    .lut_req   (lut_req),
    .lut_idx   (lut_idx),
    .lut_sel   (lut_sel),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got guard=%h low128=%h, want guard=%h low128=%h",
                  name, act[AW-1:W], act[127:0], exp[AW-1:W], exp[127:0]);
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int w = 0; w < W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rand_upper(input bit all_nz);
    logic [UW-1:0] u;
    int s;
    for (int k = 0; k < NS; k++) begin
      s = $urandom_range(0, (1 << SB) - 1);
      if (all_nz && s == 0) s = 1;
      else if (!all_nz && $urandom_range(0, 2) == 0) s = 0;
      u[k*SB +: SB] = SB'(s);
    end
    return u;
  endfunction

  // LUT bank: LUT[k][0] is zero, other entries random.
  logic [W-1:0] lut_mem [NS][1 << SB];

  logic          p_req;
  logic [IW-1:0] p_idx;
  logic [SB-1:0] p_sel;
  initial forever begin
    @(negedge clk);
    p_req = lut_req;
    p_idx = lut_idx;
    p_sel = lut_sel;
    @(posedge clk);
    #1;
    lut_data = p_req ? lut_mem[p_idx][p_sel] : rand_wide();
  end

  // Transaction-level model: expected issue list, result and latency for the current transaction.
  typedef struct {
    int idx;
    int sel;
  } iss_t;
  iss_t          m_iss[$];
  int            m_n = 0, m_lat = 0, m_k = 0;
  bit            m_ready = 1'b0, m_active = 1'b0, m_done = 1'b0;
  logic [AW-1:0] m_res = '0;

  function automatic void model_accept(input logic [W-1:0] lo, input logic [UW-1:0] up);
    logic [UW-1:0] t;
    int s;
    m_iss.delete();
    m_res = AW'(lo);
    for (int k = 0; k < NS; k++) begin
      t = up >> (k * SB);
      s = int'(t[SB-1:0]);
      if (!SKIP || s != 0) m_iss.push_back('{k, s});
      m_res = m_res + AW'(lut_mem[k][s]);
    end
    m_n   = m_iss.size();
    m_lat = ((m_n > 1) ? m_n : 1) + 2;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_ready = 1'b0; m_active = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) begin m_done = 1'b0; m_ready = 1'b1; end
    end else if (m_active) begin
      m_k++;
      if (m_k == m_lat) begin m_active = 1'b0; m_done = 1'b1; end
    end else if (!m_ready) begin
      m_ready = 1'b1;
    end else if (in_valid) begin
      model_accept(in_lower, in_upper);
      m_ready = 1'b0; m_active = 1'b1; m_k = 1;
    end
  end

  initial forever begin
    bit exp_req;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_ctl", {in_ready, out_valid, lut_req, lut_idx, lut_sel}, '0);
      check("rst_data", out_data, '0);
    end else begin
      exp_req = m_active && (m_k <= m_n);
      check("in_ready", in_ready, m_ready);
      check("out_valid", out_valid, m_done);
      check("lut_req", lut_req, exp_req);
      if (exp_req) begin
        check("lut_idx", lut_idx, m_iss[m_k-1].idx);
        check("lut_sel", lut_sel, m_iss[m_k-1].sel);
      end
      if (m_done) check("out_data", out_data, m_res);
    end
  end

  // Called at a negedge; returns at the negedge of cycle T+1 with in_valid dropped.
  task automatic send(input logic [W-1:0] lo, input logic [UW-1:0] up, output int t_acc);
    int b = 0;
    in_lower = lo; in_upper = up; in_valid = 1'b1;
    while (!in_ready && b < 50) begin @(negedge clk); b++; end
    if (!in_ready) check("send_timeout", 0, 1);
    t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_lower = rand_wide(); in_upper = rand_upper(1'b0);
  endtask

  task automatic wait_out(output int t_out);
    int b = 0;
    while (!out_valid && b < 100) begin @(negedge clk); b++; end
    if (!out_valid) check("out_timeout", 0, 1);
    t_out = cyc;
  endtask

  initial begin
    int ta, to;
    logic [W-1:0]  lo;
    logic [UW-1:0] up;
    logic [AW-1:0] ex, d0;

    for (int k = 0; k < NS; k++)
      for (int s = 0; s < (1 << SB); s++) lut_mem[k][s] = (s == 0) ? '0 : rand_wide();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Single segment seg0=1, lower=0.
    send('0, UW'(1), ta);
`ifndef XPB_ACCUM_SKIP_ZERO_EN
    for (int k = 0; k < NS; k++) begin
      check("t1_req", lut_req, 1);
      check("t1_idx", lut_idx, k);
      @(negedge clk);
    end
    wait_out(to);
    check("t1_latency", to - ta, 16);
`else
    wait_out(to);
    check("t1_latency", to - ta, 3);
`endif
    check("t1_data", out_data, AW'(lut_mem[0][1]));
    @(negedge clk);
    check("t1_ready_after_hs", in_ready, 1);

    // All-ones lower with every segment 5'h1F drives the guard bits.
    lo = '1; up = '1;
    ex = AW'(lo);
    for (int k = 0; k < NS; k++) ex = ex + AW'(lut_mem[k][(1 << SB) - 1]);
    send(lo, up, ta);
    wait_out(to);
    check("t2_latency", to - ta, 16);
    check("t2_data", out_data, ex);
    check("t2_guard_nz", out_data[AW-1:W] != '0, 1);
    @(negedge clk);

    // Backpressure in DONE.
    out_ready = 1'b0;
    send(rand_wide(), rand_upper(1'b0), ta);
    wait_out(to);
    d0 = out_data;
    repeat (10) begin
      @(negedge clk);
      check("t3_stable", out_data, d0);
      check("t3_ready_low", in_ready, 0);
      check("t3_req_low", lut_req, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_after_hs", in_ready, 1);
    check("t3_valid_dropped", out_valid, 0);

    // Reset pulse during ISSUE.
    send(rand_wide(), rand_upper(1'b1), ta);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_valid_in_rst", out_valid, 0);
    check("t4_req_in_rst", lut_req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_ready_after_rst", in_ready, 1);
    send(rand_wide(), rand_upper(1'b1), ta);
    wait_out(to);
    check("t4_latency", to - ta, 16);
    @(negedge clk);

`ifdef XPB_ACCUM_SKIP_ZERO_EN
    // Only seg3=7 and seg9=2 nonzero, then all-zero upper.
    lo = rand_wide();
    up = '0; up[3*SB +: SB] = SB'(7); up[9*SB +: SB] = SB'(2);
    send(lo, up, ta);
    check("t5_req0", lut_req, 1);
    check("t5_idx0", lut_idx, 3);
    check("t5_sel0", lut_sel, 7);
    @(negedge clk);
    check("t5_idx1", lut_idx, 9);
    check("t5_sel1", lut_sel, 2);
    @(negedge clk);
    check("t5_req_end", lut_req, 0);
    wait_out(to);
    check("t5_latency", to - ta, 4);
    check("t5_data", out_data, AW'(lo) + AW'(lut_mem[3][7]) + AW'(lut_mem[9][2]));
    @(negedge clk);
    lo = rand_wide();
    send(lo, '0, ta);
    wait_out(to);
    check("t5_zero_latency", to - ta, 3);
    check("t5_zero_data", out_data, AW'(lo));
    @(negedge clk);
`endif

    // Back-to-back transactions with out_ready held high.
    for (int i = 0; i < 3; i++) begin
      send(rand_wide(), rand_upper(1'b0), ta);
      wait_out(to);
      check("t6_latency", to - ta, m_lat);
      @(negedge clk);
      check("t6_ready_after_hs", in_ready, 1);
    end

    // Random traffic on both handshakes; the model checks every cycle.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_lower  = rand_wide();
      in_upper  = rand_upper(1'b0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
